alu_issue: RTL
==============

# alu_issue

Operand-issue stage directly upstream of the execute-stage ALU (adder, subtractor, and/or/xor/not, sla/sra/srl). Accepts decoded instructions from the decode stage over a valid/ready handshake. Forms the ALU operand pair, with optional sign-extended immediate. Generates a one-hot ALU function select and holds results in a 2-entry skid buffer, so decode and ALU are decoupled at full throughput.

## Interface
Parameters:
- DATA_W, 32, operand width; the ALU is 32-bit, so only 32 is supported.
- CNT_W, 16, width of the issued-instruction counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- flush  in  1  synchronous discard of all buffered entries.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_aluop  in  4  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not, 6 sla, 7 sra, 8 srl, 9–15 illegal.
- in_rs_data  in  DATA_W  register-file read port 1.
- in_rt_data  in  DATA_W  register-file read port 2.
- in_imm  in  16  immediate field.
- in_use_imm  in  1  select sign-extended immediate as operand b.
- in_shamt  in  5  shift amount.
- in_rd  in  5  destination register tag, carried unchanged.
- out_valid  out  1  head entry valid toward the ALU.
- out_ready  in  1  ALU/writeback consumes the head entry.
- out_a  out  DATA_W  ALU operand a.
- out_b  out  DATA_W  ALU operand b.
- out_shamt  out  5  ALU shamt.
- out_sel  out  9  one-hot ALU function enable; bit i set iff aluop == i.
- out_rd  out  5  destination tag.
- out_illegal  out  1  head entry carries an illegal aluop.
- issue_cnt  out  CNT_W  count of entries popped since reset.

## Operation
- Storage: 2-entry FIFO, head plus skid, with occupancy count 0..2.
- in_ready = (count != 2), decoded from registered count.
- Push: in_valid & in_ready. Pop: out_valid & out_ready.
- Capture-time transforms:
  - a = in_rs_data.
  - b = in_use_imm ? {{16{in_imm[15]}}, in_imm} : in_rt_data.
  - aluop 5 (not): b forced to 0.
  - shamt and rd stored unchanged. The ALU itself applies the rule "shamt==0 uses b[0]"; this stage never alters shamt.
- Illegal aluop (9–15): entry is still accepted and issued, with out_sel = 0 and out_illegal = 1. No stall, no drop.
- out_* reflect the head entry. With count == 0: out_valid = 0, and the data outputs hold their last value, not required to be 0 except after reset.
- FIFO order is strictly preserved; no entry is duplicated or lost except by flush.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged, new entry appended behind the head.
  - count == 2: push impossible; pop moves the skid entry to head.
- flush has priority over push and pop. Next cycle count = 0 and out_valid = 0. A push in the flush cycle is discarded. A pop in the flush cycle does not increment issue_cnt.
- issue_cnt increments by 1 per pop and wraps from 2^CNT_W−1 to 0. It is cleared only by rst_n, not by flush.

## Timing
- Reset values: out_valid 0, in_ready 1, out_a/out_b 0, out_shamt 0, out_sel 0, out_rd 0, out_illegal 0, issue_cnt 0, count 0.
- Reset asserted mid-transfer discards all entries immediately, asynchronously. The first push is allowed on the first rising edge after rst_n deasserts.
- Latency: push in cycle N gives out_valid = 1 in cycle N+1 when the FIFO was empty.
- Throughput: 1 entry/cycle sustained when out_ready is held high.
- Backpressure: with out_ready low, two pushes fill the FIFO and in_ready drops on the next cycle. in_ready returns high the cycle after the first pop.
- out_* remain stable while out_valid & !out_ready.
- No combinational path from in_* or out_ready to out_*; out_ready reaches in_ready only through count.

## Test plan
- Add with immediate: in_aluop=0, rs=0x0000_0010, imm=0xFFFE, use_imm=1 → next cycle out_valid=1, a=0x10, b=0xFFFF_FFFE, out_sel=9'h001.
- Backpressure: out_ready=0, push sub then xor → in_ready=0 after 2nd push. Raise out_ready → sub issued first, then xor (out_sel 9'h002 then 9'h010); issue_cnt=2.
- Streaming: 10 back-to-back pushes with out_ready=1 → 10 consecutive out_valid cycles in order, in_ready never low.
- not/illegal: aluop=5, rt=0xDEAD → b=0, out_sel=9'h020. aluop=12 → out_sel=0, out_illegal=1, still issued.
- Flush on full FIFO with a simultaneous push and pop → next cycle out_valid=0, in_ready=1, issue_cnt unchanged.
- Async reset asserted mid-stream → all outputs return to reset values without a clock edge. Preload issue_cnt to 0xFFFF, pop one → issue_cnt wraps to 0.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: operand-issue stage in front of the execute ALU.
// Forms operands and a one-hot function select, then buffers them in a 2-entry skid FIFO.
`default_nettype none

module alu_issue #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_aluop,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [15:0]       in_imm,
  input  logic              in_use_imm,
  input  logic [4:0]        in_shamt,
  input  logic [4:0]        in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [4:0]        out_shamt,
  output logic [8:0]        out_sel,
  output logic [4:0]        out_rd,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  issue_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [4:0]        shamt;
    logic [8:0]        sel;
    logic [4:0]        rd;
    logic              illegal;
  } entry_t;

  entry_t     head;
  entry_t     skid;
  entry_t     new_entry;
  logic [1:0] count;
  logic       push;
  logic       pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Operand formation happens at capture so the outputs are purely registered.
  always_comb begin
    new_entry         = '0;
    new_entry.a       = in_rs_data;
    new_entry.b       = in_use_imm ? {{(DATA_W-16){in_imm[15]}}, in_imm} : in_rt_data;
    if (in_aluop == 4'd5) begin
      new_entry.b = '0;
    end
    new_entry.shamt   = in_shamt;
    new_entry.rd      = in_rd;
    new_entry.illegal = (in_aluop > 4'd8);
    new_entry.sel     = new_entry.illegal ? 9'd0 : (9'd1 << in_aluop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= 2'd0;
      head      <= '0;
      skid      <= '0;
      issue_cnt <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      if (pop) begin
        issue_cnt <= issue_cnt + CNT_W'(1);
      end
      case (count)
        2'd0: begin
          if (push) begin
            head  <= new_entry;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head <= new_entry;
          end else if (push) begin
            skid  <= new_entry;
            count <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        default: begin
          // Full: no push possible, a pop promotes the skid entry.
          if (pop) begin
            head  <= skid;
            count <= 2'd1;
          end
        end
      endcase
    end
  end

  assign out_a       = head.a;
  assign out_b       = head.b;
  assign out_shamt   = head.shamt;
  assign out_sel     = head.sel;
  assign out_rd      = head.rd;
  assign out_illegal = head.illegal;

endmodule

`default_nettype wire
